// File: rtl/bsg_round_robin_1_to_n_buffered_pkg.sv
// Shared constants and types for the buffered 1-to-n round-robin demultiplexer.
package bsg_round_robin_1_to_n_buffered_pkg;

    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/bsg_round_robin_1_to_n_fifo_ch.sv
// Two-entry per-channel FIFO; enqueue is only offered while ready_o is high.
module bsg_round_robin_1_to_n_fifo_ch
    import bsg_round_robin_1_to_n_buffered_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    fifo_state_e        state_q;
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [width_p-1:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (v_i)    wr_ptr_q <= ~wr_ptr_q;
            if (yumi_i) rd_ptr_q <= ~rd_ptr_q;
            unique case (state_q)
                EMPTY:   if (v_i) state_q <= ONE;
                ONE: begin
                    if (v_i && !yumi_i)      state_q <= FULL;
                    else if (!v_i && yumi_i) state_q <= EMPTY;
                end
                FULL:    if (yumi_i) state_q <= ONE;
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Storage is left unreset; v_o masks its contents until written.
    always_ff @(posedge clk_i) begin
        if (v_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign ready_o = (state_q != FULL);
    assign v_o     = (state_q != EMPTY);
    assign data_o  = mem_q[rd_ptr_q];

    a_no_deq_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_i |-> (state_q != EMPTY));
    a_no_enq_full: assert property (@(posedge clk_i) disable iff (reset_i)
        v_i |-> (state_q != FULL));

endmodule

// File: rtl/bsg_round_robin_1_to_n_buffered.sv
// Steers a tagged {v, data, tag} stream into per-channel 2-entry FIFOs.
module bsg_round_robin_1_to_n_buffered
    import bsg_round_robin_1_to_n_buffered_pkg::*;
#(
    parameter int width_p   = 32,
    parameter int num_out_p = 8,
    localparam int tag_width_lp = (num_out_p > 1) ? $clog2(num_out_p) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    input  logic [tag_width_lp-1:0]      tag_i,
    output logic                         yumi_o,
    output logic [num_out_p-1:0]         v_o,
    output logic [num_out_p*width_p-1:0] data_o,
    input  logic [num_out_p-1:0]         yumi_i,
    output logic                         drop_o
);

    localparam logic [tag_width_lp:0] num_out_lp = (tag_width_lp+1)'(num_out_p);

    logic                 in_range;
    logic                 ready_sel;
    logic [num_out_p-1:0] ready;
    logic [num_out_p-1:0] enq;
    logic                 drop_d;
    logic                 drop_q;

    assign in_range = ({1'b0, tag_i} < num_out_lp);

    // Explicit mux keeps out-of-range tags from indexing past the ready vector.
    always_comb begin
        ready_sel = 1'b0;
        for (int unsigned k = 0; k < num_out_p; k++) begin
            if (tag_i == tag_width_lp'(k)) ready_sel = ready[k];
        end
    end

    assign yumi_o = v_i & (~in_range | ready_sel);
    assign drop_d = v_i & ~in_range;

    for (genvar k = 0; k < num_out_p; k++) begin : g_ch
        assign enq[k] = v_i & in_range & (tag_i == tag_width_lp'(k)) & ready[k];

        bsg_round_robin_1_to_n_fifo_ch #(
            .width_p(width_p)
        ) u_fifo (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .v_i    (enq[k]),
            .data_i (data_i),
            .ready_o(ready[k]),
            .v_o    (v_o[k]),
            .data_o (data_o[k*width_p +: width_p]),
            .yumi_i (yumi_i[k])
        );
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) drop_q <= 1'b0;
        else         drop_q <= drop_d;
    end

    assign drop_o = drop_q;

endmodule

// File: tb/tb_bsg_round_robin_1_to_n_buffered.sv
// Directed and random checks of the buffered 1-to-n demux against a queue model.
module tb_bsg_round_robin_1_to_n_buffered;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        v_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [2:0]  tag_i = '0;
    logic        yumi_o;
    logic [7:0]  v_o;
    logic [255:0] data_o;
    logic [7:0]  yumi_i = '0;
    logic        drop_o;

    logic        v6_i = 1'b0;
    logic [31:0] data6_i = '0;
    logic [2:0]  tag6_i = '0;
    logic        yumi6_o;
    logic [5:0]  v6_o;
    logic [191:0] data6_o;
    logic [5:0]  yumi6_i = '0;
    logic        drop6_o;

    int errors = 0;
    int checks = 0;

    // Reference model: per-channel ordered list of up to two words.
    logic [31:0] mq [8][2];
    int          cnt [8];
    logic        last_yumi;

    always #5 clk = ~clk;

    bsg_round_robin_1_to_n_buffered #(.width_p(32), .num_out_p(8)) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v_i), .data_i(data_i), .tag_i(tag_i),
        .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .drop_o(drop_o)
    );

    bsg_round_robin_1_to_n_buffered #(.width_p(32), .num_out_p(6)) dut6 (
        .clk_i(clk), .reset_i(reset), .v_i(v6_i), .data_i(data6_i), .tag_i(tag6_i),
        .yumi_o(yumi6_o), .v_o(v6_o), .data_o(data6_o), .yumi_i(yumi6_i), .drop_o(drop6_o)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) cnt[k] = 0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("v_o[%0d]", k), 64'(v_o[k]), 64'(cnt[k] > 0));
            if (cnt[k] > 0)
                chk($sformatf("data_o[%0d]", k), 64'(data_o[k*32 +: 32]), 64'(mq[k][0]));
        end
        chk("drop_o", 64'(drop_o), 64'(0));
    endtask

    // One clock cycle on the 8-channel DUT; entered and left at posedge+1.
    task automatic step(input logic v, input logic [2:0] tag, input logic [31:0] d,
                        input logic [7:0] yi);
        logic exp_y;
        v_i = v; tag_i = tag; data_i = d; yumi_i = yi;
        exp_y = v && (cnt[tag] < 2);
        #1;
        last_yumi = yumi_o;
        chk("yumi_o", 64'(yumi_o), 64'(exp_y));
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (yi[k] && cnt[k] > 0) begin
                mq[k][0] = mq[k][1];
                cnt[k]--;
            end
        end
        if (exp_y) begin
            mq[tag][cnt[tag]] = d;
            cnt[tag]++;
        end
        #1;
        check_outputs();
        v_i = 1'b0; yumi_i = '0;
    endtask

    initial begin
        logic [7:0] mask;
        model_clear();

        // Reset then idle
        #12;
        chk("rst_v_o", 64'(v_o), 64'h00);
        chk("rst_drop_o", 64'(drop_o), 64'h0);
        chk("rst_yumi_o", 64'(yumi_o), 64'h0);
        chk("rst_v6_o", 64'(v6_o), 64'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 3'd0, 32'h0, 8'h00);

        // Single word
        step(1'b1, 3'd3, 32'hDEADBEEF, 8'h00);
        chk("single_yumi", 64'(last_yumi), 64'h1);
        chk("single_v_o", 64'(v_o), 64'h08);
        chk("single_data", 64'(data_o[127:96]), 64'hDEADBEEF);
        step(1'b0, 3'd0, 32'h0, 8'h08);

        // Backpressure on channel 5
        step(1'b1, 3'd5, 32'h1, 8'h00);
        step(1'b1, 3'd5, 32'h2, 8'h00);
        step(1'b1, 3'd5, 32'h3, 8'h00);
        chk("bp_third_rejected", 64'(last_yumi), 64'h0);
        step(1'b1, 3'd5, 32'h3, 8'h20);
        chk("bp_full_no_enq", 64'(last_yumi), 64'h0);
        chk("bp_head", 64'(data_o[5*32 +: 32]), 64'h2);
        step(1'b1, 3'd5, 32'h3, 8'h00);
        chk("bp_accept", 64'(last_yumi), 64'h1);

        // Independence: channel 5 still full
        step(1'b1, 3'd0, 32'hA5, 8'h00);
        chk("indep_yumi", 64'(last_yumi), 64'h1);
        chk("indep_v0", 64'(v_o[0]), 64'h1);
        step(1'b0, 3'd0, 32'h0, 8'h01);

        // Simultaneous enqueue and dequeue on channel 2
        step(1'b1, 3'd2, 32'h11, 8'h00);
        step(1'b1, 3'd2, 32'h22, 8'h04);
        chk("simul_v2", 64'(v_o[2]), 64'h1);
        chk("simul_head", 64'(data_o[2*32 +: 32]), 64'h22);
        step(1'b0, 3'd0, 32'h0, 8'h04);
        chk("simul_one_only", 64'(v_o[2]), 64'h0);

        // Async reset mid-cycle
        step(1'b1, 3'd1, 32'h1111, 8'h00);
        step(1'b1, 3'd7, 32'h7777, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_v_o", 64'(v_o), 64'h00);
        model_clear();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 3'd1, 32'h0BAD_F00D, 8'h00);
        chk("post_reset_v_o", 64'(v_o), 64'h02);
        chk("post_reset_data", 64'(data_o[63:32]), 64'h0BADF00D);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            mask = '0;
            for (int k = 0; k < 8; k++) mask[k] = (cnt[k] > 0);
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
                 8'($urandom) & mask);
        end

        // Six-channel variant: out-of-range tags are dropped
        v6_i = 1'b1; tag6_i = 3'd7; data6_i = 32'h5A5A;
        #1;
        chk("n6_yumi_tag7", 64'(yumi6_o), 64'h1);
        @(posedge clk);
        #1;
        v6_i = 1'b0;
        chk("n6_drop_pulse", 64'(drop6_o), 64'h1);
        chk("n6_v_o_unchanged", 64'(v6_o), 64'h00);
        @(posedge clk);
        #1;
        chk("n6_drop_one_cycle", 64'(drop6_o), 64'h0);
        v6_i = 1'b1; tag6_i = 3'd4; data6_i = 32'h44;
        #1;
        chk("n6_yumi_tag4", 64'(yumi6_o), 64'h1);
        @(posedge clk);
        #1;
        v6_i = 1'b0;
        chk("n6_v_o_tag4", 64'(v6_o), 64'h10);
        chk("n6_data_tag4", 64'(data6_o[4*32 +: 32]), 64'h44);
        chk("n6_no_drop", 64'(drop6_o), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
